bus_router: RTL and testbench

BUS_ROUTER -- requirements
Module: bus_router

---
 rtl/bus_router_pkg.sv | 25 ++
 rtl/bus_prefix_decoder.sv | 42 ++++
 rtl/bus_router.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_router.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_router_pkg.sv
// Shared types and constants for the bus router and its prefix decoder.
// The optional abort path is enabled by defining BUS_ROUTER_TIMEOUT_EN.
package bus_router_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned IRQ_W  = 6;
  localparam int unsigned CNT_W  = 16;

  // Read data returned on a decode miss or an aborted access
  localparam logic [DATA_W-1:0] ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Index width for n slaves; a single slave still needs one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_prefix_decoder.sv
// Priority prefix matcher: the lowest-indexed slave whose masked prefix
// equals the masked address MSBs wins.
module bus_prefix_decoder
  import bus_router_pkg::*;
#(
  parameter int unsigned NUM_SLAVES   = 8,
  parameter int unsigned PREFIX_WIDTH = 12,
  parameter int unsigned IDX_W        = 3
) (
  input  logic [PREFIX_WIDTH-1:0]                 addr_prefix,
  input  logic [NUM_SLAVES-1:0][PREFIX_WIDTH-1:0] prefix,
  input  logic [NUM_SLAVES-1:0][PREFIX_WIDTH-1:0] prefix_mask,
  output logic                                    hit,
  output logic [NUM_SLAVES-1:0]                   onehot,
  output logic [IDX_W-1:0]                        idx
);

  logic [NUM_SLAVES-1:0] match;

  // Per-slave masked compare
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match[i] = ((addr_prefix & prefix_mask[i]) == (prefix[i] & prefix_mask[i]));
    end
  end

  // Lowest matching index wins
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (match[i] && !hit) begin
        hit       = 1'b1;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_router.sv
// Single-master to NUM_SLAVES address-decoded bus router with zero added
// latency on unstalled accesses. A stalled access locks the route to the
// selected slave until it completes. Define BUS_ROUTER_TIMEOUT_EN to abort
// accesses stalled for TIMEOUT_CYCLES busy cycles and drain via RECOVER.
module bus_router
  import bus_router_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned PREFIX_WIDTH   = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [ADDR_W-1:0]                       m_address,
  input  logic                                    m_read,
  input  logic                                    m_write,
  input  logic [DATA_W-1:0]                       m_data_wr,
  input  logic [MASK_W-1:0]                       m_mask,
  output logic                                    m_stall,
  output logic [DATA_W-1:0]                       m_data_rd,
  output logic [DATA_W-1:0]                       m_data_rd_2,
  output logic [IRQ_W-1:0]                        m_interrupt,
  output logic [ADDR_W-1:0]                       s_address,
  output logic [DATA_W-1:0]                       s_data_wr,
  output logic [MASK_W-1:0]                       s_mask,
  output logic [NUM_SLAVES-1:0]                   s_read,
  output logic [NUM_SLAVES-1:0]                   s_write,
  input  logic [NUM_SLAVES-1:0]                   s_stall,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]       s_data_rd,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]       s_data_rd_2,
  input  logic [NUM_SLAVES-1:0][IRQ_W-1:0]        s_interrupt,
  input  logic [NUM_SLAVES-1:0][PREFIX_WIDTH-1:0] prefix,
  input  logic [NUM_SLAVES-1:0][PREFIX_WIDTH-1:0] prefix_mask,
  output logic                                    bus_error,
  output logic [ADDR_W-1:0]                       err_address
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

  // Elaboration-time parameter range checks
  if (NUM_SLAVES == 0 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("bus_router: NUM_SLAVES must be 1..16");
  end
  if (PREFIX_WIDTH == 0 || PREFIX_WIDTH > ADDR_W) begin : g_bad_prefix_width
    $error("bus_router: PREFIX_WIDTH must be 1..32");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_router: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic                  req, rd_req, wr_req;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] grant;
  logic                  fwd_en;
  logic [IDX_W-1:0]      fwd_idx;
  logic                  recov_stall;
  logic                  miss;
  logic                  abort;
  logic [IRQ_W-1:0]      irq_or;

`ifdef BUS_ROUTER_TIMEOUT_EN
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     busy_addr_q;
`endif

  // Both strobes high is treated as a read
  assign req    = m_read | m_write;
  assign rd_req = m_read;
  assign wr_req = m_write & ~m_read;

  // Request payload is broadcast to every slave
  assign s_address = m_address;
  assign s_data_wr = m_data_wr;
  assign s_mask    = m_mask;

  bus_prefix_decoder #(
    .NUM_SLAVES   (NUM_SLAVES),
    .PREFIX_WIDTH (PREFIX_WIDTH),
    .IDX_W        (IDX_W)
  ) u_decoder (
    .addr_prefix (m_address[ADDR_W-1 -: PREFIX_WIDTH]),
    .prefix      (prefix),
    .prefix_mask (prefix_mask),
    .hit         (dec_hit),
    .onehot      (dec_onehot),
    .idx         (dec_idx)
  );

  // Next-state and route selection
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    grant       = '0;
    fwd_en      = 1'b0;
    fwd_idx     = sel_q;
    recov_stall = 1'b0;
    miss        = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_hit) begin
            grant   = dec_onehot;
            fwd_en  = 1'b1;
            fwd_idx = dec_idx;
            if (s_stall[dec_idx]) begin
              state_d = BUSY;
              sel_d   = dec_idx;
            end
          end else begin
            miss = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!s_stall[sel_q]) begin
          grant   = NUM_SLAVES'(1) << sel_q;
          fwd_en  = 1'b1;
          state_d = IDLE;
        end
`ifdef BUS_ROUTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          abort   = 1'b1;
          state_d = RECOVER;
        end
`endif
        else begin
          grant  = NUM_SLAVES'(1) << sel_q;
          fwd_en = 1'b1;
        end
      end
`ifdef BUS_ROUTER_TIMEOUT_EN
      RECOVER: begin
        recov_stall = 1'b1;
        if (!s_stall[sel_q]) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Master-facing and strobe outputs; silent while idle or in reset
  always_comb begin
    s_read      = '0;
    s_write     = '0;
    m_stall     = 1'b0;
    m_data_rd   = ERR_DATA;
    m_data_rd_2 = ERR_DATA;
    if (!rst && req) begin
      s_read  = rd_req ? grant : '0;
      s_write = wr_req ? grant : '0;
      m_stall = recov_stall | (fwd_en & s_stall[fwd_idx]);
      if (fwd_en) begin
        m_data_rd   = s_data_rd[fwd_idx];
        m_data_rd_2 = s_data_rd_2[fwd_idx];
      end
    end
  end

  // Interrupt aggregation
  always_comb begin
    irq_or = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      irq_or = irq_or | s_interrupt[i];
    end
  end

  // State and locked-route register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef BUS_ROUTER_TIMEOUT_EN
  // Saturating busy-cycle counter and address of the outstanding access
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      busy_addr_q <= '0;
    end else begin
      if (state_q == BUSY) begin
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
      if (state_q == IDLE && state_d == BUSY) begin
        busy_addr_q <= m_address;
      end
    end
  end
`endif

  // Error pulse, error address and registered interrupt OR
  always_ff @(posedge clk) begin
    if (rst) begin
      m_interrupt <= '0;
      bus_error   <= 1'b0;
      err_address <= '0;
    end else begin
      m_interrupt <= irq_or;
      bus_error   <= miss | abort;
      if (miss) begin
        err_address <= m_address;
      end
`ifdef BUS_ROUTER_TIMEOUT_EN
      else if (abort) begin
        err_address <= busy_addr_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: a transaction-level model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_bus_router;

  localparam int NS = 8;
  localparam int PW = 12;
  localparam int TO = 10;
`ifdef BUS_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [31:0]             m_address;
  logic                    m_read, m_write;
  logic [31:0]             m_data_wr;
  logic [3:0]              m_mask;
  logic                    m_stall;
  logic [31:0]             m_data_rd, m_data_rd_2;
  logic [5:0]              m_interrupt;
  logic [31:0]             s_address, s_data_wr;
  logic [3:0]              s_mask;
  logic [NS-1:0]           s_read, s_write;
  logic [NS-1:0]           s_stall;
  logic [NS-1:0][31:0]     s_data_rd, s_data_rd_2;
  logic [NS-1:0][5:0]      s_interrupt;
  logic [NS-1:0][PW-1:0]   prefix, prefix_mask;
  logic                    bus_error;
  logic [31:0]             err_address;

  bus_router #(.NUM_SLAVES(NS), .PREFIX_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_mask(m_mask), .m_stall(m_stall),
    .m_data_rd(m_data_rd), .m_data_rd_2(m_data_rd_2), .m_interrupt(m_interrupt),
    .s_address(s_address), .s_data_wr(s_data_wr), .s_mask(s_mask),
    .s_read(s_read), .s_write(s_write), .s_stall(s_stall),
    .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2), .s_interrupt(s_interrupt),
    .prefix(prefix), .prefix_mask(prefix_mask),
    .bus_error(bus_error), .err_address(err_address)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          locked = 1'b0;
  bit          recovering = 1'b0;
  int          lock_sel = 0;
  logic [31:0] lock_addr = '0;
  int          stall_cnt = 0;
  logic [5:0]  exp_irq = '0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_err_addr = '0;

  typedef struct {
    logic [NS-1:0] rd;
    logic [NS-1:0] wr;
    logic          stall;
    logic [31:0]   d1;
    logic [31:0]   d2;
    bit            miss;
    bit            abort;
    bit            lock;
    bit            done;
    int            tgt;
  } pred_t;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a[31:20] & prefix_mask[i]) == (prefix[i] & prefix_mask[i])) return i;
    end
    return -1;
  endfunction

  function automatic logic [5:0] irq_all();
    logic [5:0] r = '0;
    for (int i = 0; i < NS; i++) r = r | s_interrupt[i];
    return r;
  endfunction

  function automatic pred_t predict();
    pred_t p;
    bit    fwd = 1'b0;
    bit    req = m_read | m_write;
    int    t = -1;
    p.rd = '0; p.wr = '0; p.stall = 1'b0; p.d1 = '0; p.d2 = '0;
    p.miss = 1'b0; p.abort = 1'b0; p.lock = 1'b0; p.done = 1'b0;
    if (recovering) begin
      p.stall = req;
    end else if (locked) begin
      t = lock_sel;
      if (!s_stall[t]) begin
        p.done = 1'b1;
        fwd    = 1'b1;
      end else if (TO_EN && stall_cnt >= TO) begin
        p.abort = 1'b1;
      end else begin
        fwd = 1'b1;
      end
    end else if (req) begin
      t = decode(m_address);
      if (t < 0) p.miss = 1'b1;
      else begin
        fwd    = 1'b1;
        p.lock = s_stall[t];
      end
    end
    p.tgt = t;
    if (fwd && req) begin
      if (m_read) p.rd[t] = 1'b1;
      else        p.wr[t] = 1'b1;
      p.stall = s_stall[t];
      p.d1    = s_data_rd[t];
      p.d2    = s_data_rd_2[t];
    end
    if (rst) begin
      p.rd = '0; p.wr = '0; p.stall = 1'b0; p.d1 = '0; p.d2 = '0;
    end
    return p;
  endfunction

  // Model state advance
  always @(posedge clk) begin
    pred_t p;
    p = predict();
    if (rst) begin
      locked       <= 1'b0;
      recovering   <= 1'b0;
      stall_cnt    <= 0;
      exp_irq      <= '0;
      exp_err      <= 1'b0;
      exp_err_addr <= '0;
    end else begin
      exp_irq <= irq_all();
      exp_err <= p.miss | p.abort;
      if (p.miss)       exp_err_addr <= m_address;
      else if (p.abort) exp_err_addr <= lock_addr;
      if (recovering) begin
        if (!s_stall[lock_sel]) recovering <= 1'b0;
      end else if (locked) begin
        if (p.done) locked <= 1'b0;
        else if (p.abort) begin
          locked     <= 1'b0;
          recovering <= 1'b1;
        end else stall_cnt <= stall_cnt + 1;
      end else if (p.lock) begin
        locked    <= 1'b1;
        lock_sel  <= p.tgt;
        lock_addr <= m_address;
        stall_cnt <= 0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    pred_t p;
    if (chk_en) begin
      p = predict();
      chk("s_read",      32'(s_read),      32'(p.rd));
      chk("s_write",     32'(s_write),     32'(p.wr));
      chk("m_stall",     32'(m_stall),     32'(p.stall));
      chk("m_data_rd",   m_data_rd,        p.d1);
      chk("m_data_rd_2", m_data_rd_2,      p.d2);
      chk("m_interrupt", 32'(m_interrupt), 32'(exp_irq));
      chk("bus_error",   32'(bus_error),   32'(exp_err));
      chk("err_address", err_address,      exp_err_addr);
      chk("s_address",   s_address,        m_address);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; m_address = '0; m_read = 1'b0; m_write = 1'b0;
    m_data_wr = 32'hA5A5_0001; m_mask = 4'hF;
    s_stall = '0; s_interrupt = '0;
    for (int i = 0; i < NS; i++) begin
      s_data_rd[i]   = 32'hD000_0000 | (32'(i) * 32'h111);
      s_data_rd_2[i] = 32'hE000_0000 | 32'(i);
    end
    prefix[0] = 12'h100; prefix_mask[0] = 12'hF00;
    prefix[1] = 12'h001; prefix_mask[1] = 12'hFFF;
    prefix[2] = 12'h020; prefix_mask[2] = 12'hFF0;
    prefix[3] = 12'h030; prefix_mask[3] = 12'hFF0;
    prefix[4] = 12'h040; prefix_mask[4] = 12'hFF0;
    prefix[5] = 12'h000; prefix_mask[5] = 12'hFF0;
    prefix[6] = 12'h060; prefix_mask[6] = 12'hFF0;
    prefix[7] = 12'h070; prefix_mask[7] = 12'hFFF;

    next_cycle();
    next_cycle();
    chk_en = 1'b1;
    #2;
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_err_addr", err_address, 32'h0);
    chk("rst_irq", 32'(m_interrupt), 32'h0);
    next_cycle();
    rst = 1'b0;

    // idle, and raise interrupts
    s_interrupt[1] = 6'h01; s_interrupt[7] = 6'h20;
    #2;
    chk("idle_strobes", 32'(s_read | s_write), 32'h0);
    chk("idle_stall", 32'(m_stall), 32'h0);
    chk("idle_data", m_data_rd, 32'h0);
    next_cycle();

    // UART read, no stall
    s_interrupt = '0;
    m_address = 32'h0300_0004; m_read = 1'b1;
    #2;
    chk("uart_s_read", 32'(s_read), 32'h08);
    chk("uart_data", m_data_rd, 32'hD000_0333);
    chk("uart_data2", m_data_rd_2, 32'hE000_0003);
    chk("uart_stall", 32'(m_stall), 32'h0);
    chk("irq_or", 32'(m_interrupt), 32'h21);
    next_cycle();

    // overlapping slaves 1 and 5
    m_address = 32'h0012_3400;
    #2;
    chk("overlap_s_read", 32'(s_read), 32'h02);
    chk("overlap_data", m_data_rd, 32'hD000_0111);
    next_cycle();

    // slave 2 write stalls 4 cycles, address moves in cycle 2
    m_read = 1'b0; m_write = 1'b1; m_address = 32'h0200_0010; s_stall[2] = 1'b1;
    #2;
    chk("stall_c1_wr", 32'(s_write), 32'h04);
    chk("stall_c1_stall", 32'(m_stall), 32'h1);
    next_cycle();
    m_address = 32'h0012_3400;
    #2;
    chk("stall_c2_wr", 32'(s_write), 32'h04);
    chk("stall_c2_rd", 32'(s_read), 32'h0);
    chk("stall_c2_stall", 32'(m_stall), 32'h1);
    next_cycle();
    next_cycle();
    next_cycle();
    s_stall[2] = 1'b0;
    #2;
    chk("stall_c5_wr", 32'(s_write), 32'h04);
    chk("stall_c5_stall", 32'(m_stall), 32'h0);
    next_cycle();
    m_write = 1'b0;
    #2;
    chk("stall_c6_wr", 32'(s_write), 32'h0);
    next_cycle();

    // unmapped read
    m_read = 1'b1; m_address = 32'h0900_0000;
    #2;
    chk("miss_stall", 32'(m_stall), 32'h0);
    chk("miss_data", m_data_rd, 32'h0);
    chk("miss_strobe", 32'(s_read), 32'h0);
    next_cycle();
    m_read = 1'b0;
    #2;
    chk("miss_bus_error", 32'(bus_error), 32'h1);
    chk("miss_err_addr", err_address, 32'h0900_0000);
    next_cycle();
    #2;
    chk("miss_pulse_end", 32'(bus_error), 32'h0);
    next_cycle();

    // slave 4 stalls for a long time
    m_read = 1'b1; m_address = 32'h0400_0000; s_stall[4] = 1'b1;
`ifdef BUS_ROUTER_TIMEOUT_EN
    repeat (11) next_cycle();
    #2;
    chk("to_abort_stall", 32'(m_stall), 32'h0);
    chk("to_abort_strobe", 32'(s_read), 32'h0);
    chk("to_abort_data", m_data_rd, 32'h0);
    next_cycle();
    #2;
    chk("to_bus_error", 32'(bus_error), 32'h1);
    chk("to_err_addr", err_address, 32'h0400_0000);
    chk("to_recover_stall", 32'(m_stall), 32'h1);
    chk("to_recover_strobe", 32'(s_read), 32'h0);
    next_cycle();
    s_stall[4] = 1'b0;
    #2;
    chk("to_pulse_end", 32'(bus_error), 32'h0);
    next_cycle();
    #2;
    chk("to_idle_strobe", 32'(s_read), 32'h10);
    chk("to_idle_stall", 32'(m_stall), 32'h0);
`else
    repeat (15) next_cycle();
    #2;
    chk("wait_stall", 32'(m_stall), 32'h1);
    chk("wait_strobe", 32'(s_read), 32'h10);
    chk("wait_no_error", 32'(bus_error), 32'h0);
    next_cycle();
    s_stall[4] = 1'b0;
    #2;
    chk("wait_done_stall", 32'(m_stall), 32'h0);
    chk("wait_done_strobe", 32'(s_read), 32'h10);
`endif
    next_cycle();
    m_read = 1'b0;
    next_cycle();

    // reset while BUSY on slave 6
    m_write = 1'b1; m_address = 32'h0600_0000; s_stall[6] = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #2;
    chk("rst_busy_strobe", 32'(s_write), 32'h0);
    chk("rst_busy_stall", 32'(m_stall), 32'h0);
    next_cycle();
    rst = 1'b0; m_address = 32'h0200_0000;
    #2;
    chk("post_rst_err_addr", err_address, 32'h0);
    chk("post_rst_strobe", 32'(s_write), 32'h04);
    chk("post_rst_stall", 32'(m_stall), 32'h0);
    next_cycle();
    m_write = 1'b0; s_stall = '0;
    next_cycle();

    // both strobes high behaves as a read
    m_read = 1'b1; m_write = 1'b1; m_address = 32'h0700_0000;
    #2;
    chk("rw_s_read", 32'(s_read), 32'h80);
    chk("rw_s_write", 32'(s_write), 32'h0);
    next_cycle();
    m_read = 1'b0; m_write = 1'b0;
    next_cycle();
    next_cycle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
